// File: rtl/mont_mult_if.sv
// mont_mult_if: operand/result handshake between the exp controller and mont_mult
interface mont_mult_if #(parameter int WIDTH = 256);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] result;
  logic             ready;
  logic             busy;
  modport master (output start, a, b, n, input result, ready, busy);
  modport slave  (input start, a, b, n, output result, ready, busy);
endinterface

// File: rtl/mont_mult.sv
// mont_mult: bit-serial Montgomery multiplier, result = a*b*2^-WIDTH mod n
module mont_mult #(
  parameter int WIDTH = 256
) (
  input logic        clk,
  input logic        rst,
  mont_mult_if.slave m
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, LOOP, FINAL, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg, n_reg;
  logic [WIDTH+1:0] acc, t0, t1, acc_sub, n_ext;
  logic [CW-1:0]    cnt;
  // two spare bits keep the sum below 4n without overflow
  always_comb begin
    n_ext   = {2'b00, n_reg};
    t0      = acc + (a_reg[cnt[CW-2:0]] ? {2'b00, b_reg} : '0);
    t1      = t0 + (t0[0] ? n_ext : '0);
    acc_sub = acc - n_ext;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      n_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      m.result <= '0;
      m.ready  <= 1'b0;
      m.busy   <= 1'b0;
    end else if (m.start) begin
      state   <= LOOP;
      a_reg   <= m.a;
      b_reg   <= m.b;
      n_reg   <= m.n;
      acc     <= '0;
      cnt     <= '0;
      m.ready <= 1'b0;
      m.busy  <= 1'b1;
    end else begin
      case (state)
        LOOP: begin
          acc   <= t1 >> 1;
          cnt   <= cnt + 1'b1;
          state <= (cnt == CW'(WIDTH - 1)) ? FINAL : LOOP;
        end
        FINAL: begin
          m.result <= (acc >= n_ext) ? acc_sub[WIDTH-1:0] : acc[WIDTH-1:0];
          m.ready  <= 1'b1;
          m.busy   <= 1'b0;
          state    <= DONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mont_mult.sv
// tb_mont_mult: vector table plus scoreboard bench for mont_mult at WIDTH=8 and WIDTH=256
module tb_mont_mult;
  logic clk, rst;
  int checks = 0;
  int failures = 0;
  mont_mult_if #(.WIDTH(8))   i8 ();
  mont_mult_if #(.WIDTH(256)) i256 ();
  mont_mult #(.WIDTH(8))   d8   (.clk(clk), .rst(rst), .m(i8));
  mont_mult #(.WIDTH(256)) d256 (.clk(clk), .rst(rst), .m(i256));
  always #5 clk = ~clk;
  logic [7:0]   q8[$];
  logic [255:0] q256[$];
  typedef struct {logic [7:0] a, b, n, r;} vec_t;
  vec_t v[9];

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] ref256(logic [255:0] a, logic [255:0] b, logic [255:0] n);
    logic [511:0] x, p, nn;
    nn = {256'b0, n};
    x = 512'd1;
    repeat (256) x = x[0] ? (x + nn) >> 1 : x >> 1;
    p = ({256'b0, a} * {256'b0, b}) % nn;
    p = (p * x) % nn;
    return p[255:0];
  endfunction

  task automatic start8(logic [7:0] a, logic [7:0] b, logic [7:0] n, logic [7:0] exp);
    i8.a = a; i8.b = b; i8.n = n; i8.start = 1'b1;
    q8.push_back(exp);
    @(negedge clk);
    i8.start = 1'b0;
    i8.a = 8'($urandom); i8.b = 8'($urandom); i8.n = 8'($urandom);
  endtask

  task automatic wait8(string name);
    int k = 0;
    bit bad_busy = 0;
    logic [7:0] exp;
    chk({name, "_ready_low"}, 256'(i8.ready), 256'd0);
    while (!i8.ready && k < 20) begin
      if (!i8.busy) bad_busy = 1;
      @(negedge clk);
      k++;
    end
    chk({name, "_latency"}, 256'(k), 256'd9);
    chk({name, "_busy_loop"}, 256'(bad_busy), 256'd0);
    chk({name, "_busy_done"}, 256'(i8.busy), 256'd0);
    if (q8.size() != 0) begin
      exp = q8.pop_front();
      chk({name, "_result"}, 256'(i8.result), 256'(exp));
    end else begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty", name);
    end
  endtask

  task automatic run256(logic [255:0] a, logic [255:0] b, logic [255:0] n);
    int k = 0;
    bit bad_busy = 0;
    i256.a = a; i256.b = b; i256.n = n; i256.start = 1'b1;
    q256.push_back(ref256(a, b, n));
    @(negedge clk);
    i256.start = 1'b0;
    i256.a = rnd256(); i256.b = rnd256(); i256.n = rnd256();
    while (!i256.ready && k < 300) begin
      if (!i256.busy) bad_busy = 1;
      @(negedge clk);
      k++;
    end
    chk("w256_latency", 256'(k), 256'd257);
    chk("w256_busy_loop", 256'(bad_busy), 256'd0);
    chk("w256_result", i256.result, q256.pop_front());
  endtask

  initial begin
    logic [255:0] a, b, n;
    clk = 1'b0; rst = 1'b1;
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.n = '0;
    i256.start = 1'b0; i256.a = '0; i256.b = '0; i256.n = '0;
    v[0] = '{8'd5, 8'd7, 8'd13, 8'd1};
    v[1] = '{8'd9, 8'd9, 8'd13, 8'd9};
    v[2] = '{8'd0, 8'd12, 8'd13, 8'd0};
    v[3] = '{8'd12, 8'd12, 8'd13, 8'd3};
    v[4] = '{8'd1, 8'd1, 8'd13, 8'd3};
    v[5] = '{8'd3, 8'd4, 8'd13, 8'd10};
    v[6] = '{8'd200, 8'd100, 8'd255, 8'd110};
    v[7] = '{8'd10, 8'd20, 8'd251, 8'd40};
    v[8] = '{8'd2, 8'd2, 8'd3, 8'd1};
    #12;
    chk("rst_result8", 256'(i8.result), 256'd0);
    chk("rst_ready8", 256'(i8.ready), 256'd0);
    chk("rst_busy8", 256'(i8.busy), 256'd0);
    chk("rst_result256", i256.result, 256'd0);
    chk("rst_ready256", 256'(i256.ready), 256'd0);
    chk("rst_busy256", 256'(i256.busy), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // consecutive entries also exercise starting on the cycle ready rises
    for (int i = 0; i < 9; i++) begin
      start8(v[i].a, v[i].b, v[i].n, v[i].r);
      wait8("vec");
    end
    start8(8'd5, 8'd7, 8'd13, 8'd1);
    repeat (3) @(negedge clk);
    chk("restart_ready_pre", 256'(i8.ready), 256'd0);
    q8.delete(0);
    start8(8'd9, 8'd9, 8'd13, 8'd9);
    wait8("restart");
    start8(8'd12, 8'd12, 8'd13, 8'd3);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_result", 256'(i8.result), 256'd0);
    chk("midrst_ready", 256'(i8.ready), 256'd0);
    chk("midrst_busy", 256'(i8.busy), 256'd0);
    rst = 1'b0;
    q8.delete(0);
    @(negedge clk);
    start8(8'd3, 8'd4, 8'd13, 8'd10);
    wait8("after_rst");
    start8(8'd5, 8'd7, 8'd13, 8'd1);
    wait8("b2b_first");
    start8(8'd12, 8'd12, 8'd13, 8'd3);
    wait8("b2b_second");
    for (int i = 0; i < 200; i++) begin
      n = rnd256() | 256'd1;
      if (n == 256'd1) n[255] = 1'b1;
      a = rnd256() % n;
      b = rnd256() % n;
      run256(a, b, n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
